rf_access_master: RTL and testbench
===================================

RF_ACCESS_MASTER -- requirements
Module: rf_access_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ACCESS cycles before abort (legal range 2..255).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 res  input  1  asynchronous active-high reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when both high at clk edge.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_address  input  ADDR_WIDTH  target register address.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when both high at clk edge.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data.
REQ-015 rsp_error  output  2  00 ok, 01 invalid address, 10 timeout.
REQ-016 address  output  ADDR_WIDTH  register-file address.
REQ-017 read_en / write_en  output  1 each  register-file strobes.
REQ-018 write_data  output  DATA_WIDTH  register-file write data.
REQ-019 read_data  input  DATA_WIDTH  register-file read data.
REQ-020 invalid_address / access_complete  input  1 each  register-file status.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-022 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL latch cmd_write/cmd_address/cmd_wdata and enter ACCESS next cycle.
REQ-023 cmd_ready SHALL be 0 in ACCESS and RESP; one outstanding transaction only.
REQ-024 First ACCESS cycle: read_en (read) or write_en (write) SHALL be 1 for exactly that one cycle; never both.
REQ-025 address and write_data SHALL hold latched values throughout ACCESS; write_data SHALL be 0 for reads.
REQ-026 ACCESS, every cycle incl. strobe cycle: invalid_address=1 -> RESP, error 01, rdata 0 (takes priority over access_complete).
REQ-027 ACCESS: access_complete=1, invalid_address=0 -> RESP, error 00; rdata = read_data sampled that cycle for reads, 0 for writes.
REQ-028 8-bit wait counter SHALL clear on entering ACCESS, increment each ACCESS cycle without completion; at count TIMEOUT-1 with no completion -> RESP, error 10, rdata 0.
REQ-029 RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_ready; on rsp_ready -> IDLE next cycle.
REQ-030 No same-cycle acceptance of a new command in RESP; minimum 3 cycles per transaction (IDLE, ACCESS, RESP).
REQ-031 access_complete/invalid_address in IDLE or RESP SHALL be ignored (no state change, no error).
REQ-032 cmd_* changes while not in IDLE SHALL not affect in-flight transaction.

Reset
REQ-033 res=1 SHALL immediately (asynchronously) force IDLE; cmd_ready=0 while res=1, 1 on first edge after release.
REQ-034 Reset values: rsp_valid=0, rsp_rdata=0, rsp_error=00, read_en=0, write_en=0, address=0, write_data=0, counter=0.
REQ-035 Reset mid-ACCESS or mid-RESP SHALL drop strobes and rsp_valid at once; transaction discarded, no response.

Verification
REQ-036 Read: cmd addr 0, RF answers access_complete one cycle after read_en with read_data 0x0000_0000_0000_002A -> single read_en pulse, rsp_valid, rdata 0x2A, error 00.
REQ-037 Write: cmd addr 0 data 0x1234, access_complete one cycle later -> single write_en pulse, write_data 0x1234 stable, rsp error 00, rdata 0.
REQ-038 Invalid: addr 0x55, invalid_address and access_complete both 1 -> error 01, rdata 0.
REQ-039 Timeout: TIMEOUT=15, RF never completes -> rsp_valid exactly 15 cycles after entering ACCESS, error 10.
REQ-040 Backpressure: rsp_ready low 5 cycles -> rsp_valid/rdata/error stable, cmd_ready 0; back-to-back second command accepted only after IDLE.
REQ-041 Reset: assert res during ACCESS -> read_en/write_en/rsp_valid 0 same cycle; after release cmd_ready=1, stray access_complete ignored.

Source files
------------

// File: rtl/rf_access_master_if.sv
// Bundle of the command/response handshakes and the register-file strobe bus
// between the access master and its environment.
interface rf_access_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_error;
    logic [ADDR_WIDTH-1:0] address;
    logic                  read_en;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  invalid_address;
    logic                  access_complete;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready,
               read_data, invalid_address, access_complete,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               address, read_en, write_en, write_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready,
               read_data, invalid_address, access_complete,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               address, read_en, write_en, write_data
    );
endinterface

// File: rtl/rf_access_master.sv
// Single-outstanding register-file access master: accepts one command, strobes the
// register file once, waits for completion/invalid/timeout, then holds the response.
module rf_access_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               res,
    rf_access_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_cmd_ready, w_cmd_ready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_error, w_rsp_error_nxt;
    logic                  r_read_en, w_read_en_nxt;
    logic                  r_write_en, w_write_en_nxt;
    logic [ADDR_WIDTH-1:0] r_address, w_address_nxt;
    logic [DATA_WIDTH-1:0] r_write_data, w_write_data_nxt;
    logic                  r_is_write, w_is_write_nxt;
    logic [7:0]            r_wait_cnt, w_wait_cnt_nxt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_error  <= 2'b00;
            r_read_en    <= 1'b0;
            r_write_en   <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
            r_is_write   <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_rsp_error  <= w_rsp_error_nxt;
            r_read_en    <= w_read_en_nxt;
            r_write_en   <= w_write_en_nxt;
            r_address    <= w_address_nxt;
            r_write_data <= w_write_data_nxt;
            r_is_write   <= w_is_write_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_ready_nxt  = r_cmd_ready;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_rsp_error_nxt  = r_rsp_error;
        w_read_en_nxt    = 1'b0;
        w_write_en_nxt   = 1'b0;
        w_address_nxt    = r_address;
        w_write_data_nxt = r_write_data;
        w_is_write_nxt   = r_is_write;
        w_wait_cnt_nxt   = r_wait_cnt;

        case (r_state)
            IDLE: begin
                // cmd_ready comes up one edge after reset release, so acceptance needs it already high
                if (r_cmd_ready && bus.cmd_valid) begin
                    w_state_nxt      = ACCESS;
                    w_cmd_ready_nxt  = 1'b0;
                    w_read_en_nxt    = !bus.cmd_write;
                    w_write_en_nxt   = bus.cmd_write;
                    w_address_nxt    = bus.cmd_address;
                    w_write_data_nxt = bus.cmd_write ? bus.cmd_wdata : '0;
                    w_is_write_nxt   = bus.cmd_write;
                    w_wait_cnt_nxt   = '0;
                end else begin
                    w_cmd_ready_nxt  = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.invalid_address) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 2'b01;
                    w_rsp_rdata_nxt = '0;
                end else if (bus.access_complete) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 2'b00;
                    w_rsp_rdata_nxt = r_is_write ? '0 : bus.read_data;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 2'b10;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_wait_cnt_nxt  = r_wait_cnt + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.read_en    = r_read_en;
    assign bus.write_en   = r_write_en;
    assign bus.address    = r_address;
    assign bus.write_data = r_write_data;
endmodule

// File: tb/tb_rf_access_master.sv
// Directed bench for rf_access_master: a time-stamped transaction model predicts
// every output each cycle, with literal expectations on the key scenarios.
module tb_rf_access_master;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    rf_access_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    rf_access_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    // Model: edge counter plus the edge number at which the current command was accepted.
    longint          cyc = 0;
    longint          acc_start = -1;
    bit              m_resp = 1'b0;
    bit              m_write = 1'b0;
    logic            e_cmd_ready = 1'b0;
    logic            e_rsp_valid = 1'b0;
    logic [DW-1:0]   e_rsp_rdata = '0;
    logic [1:0]      e_rsp_error = 2'b00;
    logic            e_read_en = 1'b0;
    logic            e_write_en = 1'b0;
    logic [AW-1:0]   e_address = '0;
    logic [DW-1:0]   e_write_data = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic respond(input logic [1:0] err, input logic [DW-1:0] data);
        acc_start   = -1;
        m_resp      = 1'b1;
        e_rsp_valid = 1'b1;
        e_rsp_error = err;
        e_rsp_rdata = data;
    endtask

    always @(posedge clk or posedge res) begin
        if (res) begin
            acc_start = -1; m_resp = 1'b0; m_write = 1'b0;
            e_cmd_ready = 1'b0; e_rsp_valid = 1'b0; e_rsp_rdata = '0; e_rsp_error = 2'b00;
            e_read_en = 1'b0; e_write_en = 1'b0; e_address = '0; e_write_data = '0;
        end else begin
            cyc++;
            e_read_en  = 1'b0;
            e_write_en = 1'b0;
            if (m_resp) begin
                if (bus.rsp_ready) begin
                    m_resp = 1'b0; e_rsp_valid = 1'b0; e_cmd_ready = 1'b1;
                end
            end else if (acc_start >= 0) begin
                if (bus.invalid_address) respond(2'b01, '0);
                else if (bus.access_complete) respond(2'b00, m_write ? '0 : bus.read_data);
                else if (cyc - acc_start == TO) respond(2'b10, '0);
            end else if (e_cmd_ready && bus.cmd_valid) begin
                acc_start    = cyc;
                m_write      = bus.cmd_write;
                e_cmd_ready  = 1'b0;
                e_read_en    = !bus.cmd_write;
                e_write_en   = bus.cmd_write;
                e_address    = bus.cmd_address;
                e_write_data = bus.cmd_write ? bus.cmd_wdata : '0;
            end else begin
                e_cmd_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready",  DW'(bus.cmd_ready),  DW'(e_cmd_ready));
        chk("rsp_valid",  DW'(bus.rsp_valid),  DW'(e_rsp_valid));
        chk("rsp_rdata",  bus.rsp_rdata,       e_rsp_rdata);
        chk("rsp_error",  DW'(bus.rsp_error),  DW'(e_rsp_error));
        chk("read_en",    DW'(bus.read_en),    DW'(e_read_en));
        chk("write_en",   DW'(bus.write_en),   DW'(e_write_en));
        chk("address",    DW'(bus.address),    DW'(e_address));
        chk("write_data", bus.write_data,      e_write_data);
        if (bus.read_en)  rd_pulses++;
        if (bus.write_en) wr_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("cmd_ready_wait", DW'(bus.cmd_ready), DW'(1));
        bus.cmd_write = wr; bus.cmd_address = addr; bus.cmd_wdata = data; bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin step(); n++; end
        if (n >= 100) chk("rsp_valid_wait", DW'(bus.rsp_valid), DW'(1));
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        res = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.read_data = '0; bus.invalid_address = 1'b0; bus.access_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", DW'(bus.cmd_ready), DW'(0));
        chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        res = 1'b0;
        step();
        chk("ready_after_rst", DW'(bus.cmd_ready), DW'(1));

        // read of address 0, completion one cycle after the strobe
        rd_pulses = 0; wr_pulses = 0;
        issue(1'b0, 8'h00, '0);
        bus.cmd_address = 8'hAA;
        step();
        bus.access_complete = 1'b1; bus.read_data = 64'h2A;
        step();
        bus.access_complete = 1'b0; bus.read_data = '0;
        wait_rsp(n);
        chk("rd_rdata", bus.rsp_rdata, 64'h2A);
        chk("rd_error", DW'(bus.rsp_error), DW'(0));
        chk("rd_pulses", DW'(rd_pulses), DW'(1));
        chk("rd_wr_pulses", DW'(wr_pulses), DW'(0));
        release_rsp();

        // write of 0x1234 to address 0
        rd_pulses = 0; wr_pulses = 0;
        issue(1'b1, 8'h00, 64'h1234);
        step();
        chk("wr_wdata", bus.write_data, 64'h1234);
        bus.access_complete = 1'b1; bus.read_data = 64'hFFFF;
        step();
        bus.access_complete = 1'b0; bus.read_data = '0;
        wait_rsp(n);
        chk("wr_rdata", bus.rsp_rdata, 64'h0);
        chk("wr_error", DW'(bus.rsp_error), DW'(0));
        chk("wr_pulses", DW'(wr_pulses), DW'(1));
        chk("wr_rd_pulses", DW'(rd_pulses), DW'(0));
        release_rsp();

        // invalid address wins over completion in the strobe cycle
        issue(1'b0, 8'h55, '0);
        bus.invalid_address = 1'b1; bus.access_complete = 1'b1; bus.read_data = 64'hDEAD;
        step();
        bus.invalid_address = 1'b0; bus.access_complete = 1'b0; bus.read_data = '0;
        wait_rsp(n);
        chk("inv_error", DW'(bus.rsp_error), DW'(2'b01));
        chk("inv_rdata", bus.rsp_rdata, 64'h0);
        release_rsp();

        // timeout: register file never answers
        issue(1'b0, 8'h10, '0);
        wait_rsp(n);
        chk("to_cycles", DW'(n), DW'(15));
        chk("to_error", DW'(bus.rsp_error), DW'(2'b10));
        release_rsp();

        // backpressure with a second command already waiting
        issue(1'b0, 8'h03, '0);
        bus.access_complete = 1'b1; bus.read_data = 64'h55AA;
        step();
        bus.access_complete = 1'b0; bus.read_data = '0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 8'h07; bus.cmd_wdata = 64'h99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", DW'(bus.cmd_ready), DW'(0));
            chk("bp_rdata", bus.rsp_rdata, 64'h55AA);
            step();
        end
        release_rsp();
        chk("bp_idle_ready", DW'(bus.cmd_ready), DW'(1));
        step();
        bus.cmd_valid = 1'b0;
        chk("bp2_write_en", DW'(bus.write_en), DW'(1));
        chk("bp2_address", DW'(bus.address), DW'(8'h07));
        step();
        bus.access_complete = 1'b1;
        step();
        bus.access_complete = 1'b0;
        wait_rsp(n);
        chk("bp2_error", DW'(bus.rsp_error), DW'(0));
        release_rsp();

        // asynchronous reset in the strobe cycle of a write
        issue(1'b1, 8'h20, 64'hABC);
        #1 res = 1'b1;
        #1;
        chk("ar_write_en", DW'(bus.write_en), DW'(0));
        chk("ar_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("ar_cmd_ready", DW'(bus.cmd_ready), DW'(0));
        @(posedge clk);
        #1 res = 1'b0;
        bus.access_complete = 1'b1; bus.invalid_address = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_stray_rsp", DW'(bus.rsp_valid), DW'(0));
        end
        bus.access_complete = 1'b0; bus.invalid_address = 1'b0;
        chk("ar_ready", DW'(bus.cmd_ready), DW'(1));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
